mem_access_unit: RTL and testbench

Data-memory access stage of the pipelined RISC-V core, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. Converts the EX/MEM load/store request into a req/ready bus transaction with byte enables, formats load data (sign/zero extension) for write-back, and stalls the pipeline while the bus is busy. Detects misaligned/illegal accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access stage between the EX/MEM and MEM/WB pipeline registers.
// Turns a load/store request into a single req/ready bus transaction with
// byte enables and lane-replicated store data, formats load data for
// write-back (sign/zero extension), and stalls the front of the pipeline
// while the bus is busy. Misaligned or illegal requests never reach the bus;
// a bus that stays silent for TIMEOUT wait cycles is abandoned and flagged.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   mem_read_in           load request (EX/MEM)
//   mem_write_in          store request (EX/MEM); wins over mem_read_in
//   funct3_in[2:0]        000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_in[31:0]         byte address
//   store_data_in[31:0]   store data (rs2)
//   bus_req               registered transaction request
//   bus_we                1 = write
//   bus_addr[31:0]        word-aligned address
//   bus_be[3:0]           byte enables
//   bus_wdata[31:0]       lane-replicated store data
//   bus_rdata[31:0]       read word, valid with bus_ready
//   bus_ready             transaction complete
//   read_data_out[31:0]   formatted load result for MEM/WB
//   stall_out             freeze PC/IF/ID/EX/EX-MEM
//   misaligned_out        current request misaligned or illegal funct3
//   bus_error_out         sticky bus-timeout flag
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic [31:0] read_data_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_reg;
  logic [7:0]  count_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  funct3_reg;

  logic        req_any;
  logic        legal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_shift;
  logic [31:0] load_data;
  logic [7:0]  count_inc;

  assign req_any = mem_read_in | mem_write_in;

  // Stores only accept B/H/W; loads additionally accept BU/HU.
  always_comb begin
    legal = 1'b0;
    case (funct3_in)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_in[0];
      3'b010:  legal = (addr_in[1:0] == 2'b00);
      3'b100:  legal = ~mem_write_in;
      3'b101:  legal = ~mem_write_in & ~addr_in[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_next = 4'b1111;
    case (funct3_in[1:0])
      2'b00:   be_next = 4'b0001 << addr_in[1:0];
      2'b01:   be_next = addr_in[1] ? 4'b1100 : 4'b0011;
      default: be_next = 4'b1111;
    endcase
  end

  // Replicate the low byte/half across every lane so the memory only has to
  // honour the byte enables.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[8*gi +: 8] =
        (funct3_in[1:0] == 2'b00) ? store_data_in[7:0] :
        (funct3_in[1:0] == 2'b01) ? store_data_in[8*(gi%2) +: 8] :
                                    store_data_in[8*gi +: 8];
    end
  endgenerate

  // Bring the addressed lane down to bit 0, then extend by access type.
  assign load_shift = bus_rdata >> {lane_reg, 3'b000};

  always_comb begin
    load_data = load_shift;
    case (funct3_reg)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {24'd0, load_shift[7:0]};
      3'b101:  load_data = {16'd0, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  assign count_inc = count_reg + 8'd1;

  // Only IDLE looks at the request; WAIT/DONE belong to the captured access,
  // so the same instruction is never issued twice.
  assign stall_out      = ((state_reg == IDLE) & req_any & legal) | (state_reg == WAIT);
  assign misaligned_out = (state_reg == IDLE) & req_any & ~legal;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= 8'd0;
      lane_reg      <= 2'b00;
      funct3_reg    <= 3'b000;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'd0;
      bus_be        <= 4'd0;
      bus_wdata     <= 32'd0;
      read_data_out <= 32'd0;
      bus_error_out <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any && legal) begin
            bus_req    <= 1'b1;
            bus_we     <= mem_write_in;
            bus_addr   <= {addr_in[31:2], 2'b00};
            bus_be     <= be_next;
            bus_wdata  <= wdata_next;
            lane_reg   <= addr_in[1:0];
            funct3_reg <= funct3_in;
            count_reg  <= 8'd0;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          // Ready is checked first so a response on the timeout edge still
          // counts as a normal completion.
          if (bus_ready) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              read_data_out <= load_data;
            end
            state_reg <= DONE;
          end else if (count_inc == TIMEOUT_CNT) begin
            bus_req       <= 1'b0;
            bus_error_out <= 1'b1;
            if (!bus_we) begin
              read_data_out <= 32'd0;
            end
            count_reg <= count_inc;
            state_reg <= DONE;
          end else begin
            count_reg <= count_inc;
          end
        end
        DONE: begin
          count_reg <= 8'd0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic [31:0] read_data_out;
  logic        stall_out, misaligned_out, bus_error_out;

  int total  = 0;
  int passed = 0;
  logic exp_err = 1'b0;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .read_data_out(read_data_out), .stall_out(stall_out),
    .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          delay;   // WAIT cycles without ready before ready
    logic        mis;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic [31:0] rd;      // read_data_out after the access
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_read_data"}, read_data_out, 32'd0);
    check({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
    check({tag, "_misaligned"}, {31'd0, misaligned_out}, 32'd0);
    check({tag, "_bus_error"}, {31'd0, bus_error_out}, 32'd0);
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic do_vec(input int idx, input vec_t v);
    int stall_cnt;
    stall_cnt     = 0;
    mem_read_in   = ~v.we;
    mem_write_in  = v.we;
    funct3_in     = v.f3;
    addr_in       = v.addr;
    store_data_in = v.sd;
    bus_ready     = v.mis;   // ready outside WAIT must be ignored
    bus_rdata     = 32'hFFFF_FFFF;
    #1;
    if (v.mis) begin
      check("illegal_misaligned", {31'd0, misaligned_out}, 32'd1);
      check("illegal_stall", {31'd0, stall_out}, 32'd0);
      repeat (2) begin
        cycle();
        check("illegal_no_req", {31'd0, bus_req}, 32'd0);
        check("illegal_rd_hold", read_data_out, v.rd);
      end
      check("illegal_still_flagged", {31'd0, misaligned_out}, 32'd1);
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      bus_ready    = 1'b0;
      #1;
      check("illegal_flag_clears", {31'd0, misaligned_out}, 32'd0);
    end else begin
      check("legal_misaligned", {31'd0, misaligned_out}, 32'd0);
      if (stall_out) stall_cnt++;
      cycle();
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      check("wait_bus_req", {31'd0, bus_req}, 32'd1);
      check("wait_bus_we", {31'd0, bus_we}, {31'd0, v.we});
      check("wait_bus_addr", bus_addr, v.baddr);
      check("wait_bus_be", {28'd0, bus_be}, {28'd0, v.be});
      if (v.we) check("wait_bus_wdata", bus_wdata, v.wdata);
      for (int k = 0; k <= v.delay; k++) begin
        if (stall_out) stall_cnt++;
        if (k == v.delay) begin
          bus_ready = 1'b1;
          bus_rdata = v.rdata;
        end
        cycle();
        bus_ready = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
      end
      check("done_bus_req", {31'd0, bus_req}, 32'd0);
      check("done_stall", {31'd0, stall_out}, 32'd0);
      check("done_read_data", read_data_out, v.rd);
      check("done_bus_error", {31'd0, bus_error_out}, {31'd0, exp_err});
      check("stall_cycles", stall_cnt, v.delay + 2);
      cycle();
    end
    $display("vec %0d: we=%0b f3=%03b addr=%h -> be=%04b rd=%h err=%0b",
             idx, v.we, v.f3, v.addr, bus_be, read_data_out, bus_error_out);
  endtask

  initial begin
    //          we    f3      addr          sd            rdata         dly mis be       baddr         wdata         rd
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h100, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1100, 32'h100, 32'h0,        32'h000080FF};
    vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 3, 1'b0, 4'b1100, 32'h100, 32'h0,        32'hFFFF80FF};
    vecs[5]  = '{1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h12345678, 0, 1'b0, 4'b0010, 32'h200, 32'hABABABAB, 32'hFFFF80FF};
    vecs[6]  = '{1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h12345678, 2, 1'b0, 4'b1100, 32'h200, 32'hCDEFCDEF, 32'hFFFF80FF};
    vecs[7]  = '{1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h12345678, 0, 1'b0, 4'b1111, 32'h204, 32'hCAFEF00D, 32'hFFFF80FF};
    vecs[8]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 1'b0, 4'b0010, 32'h100, 32'h0,        32'h0000007F};
    vecs[9]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h0000A5A5, 0, 1'b0, 4'b0011, 32'h100, 32'h0,        32'hFFFFA5A5};
    vecs[10] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,   32'h0,        32'hFFFFA5A5};
    vecs[11] = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,   32'h0,        32'hFFFFA5A5};
    vecs[12] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,   32'h0,        32'hFFFFA5A5};
    vecs[13] = '{1'b1, 3'b100, 32'h300, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,   32'h0,        32'hFFFFA5A5};

    reset = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b000;
    addr_in = 32'h0; store_data_in = 32'h0; bus_rdata = 32'h0; bus_ready = 1'b0;
    repeat (2) cycle();
    check_reset_values("reset");
    reset = 1'b0;
    cycle();

    for (int i = 0; i < 14; i++) do_vec(i, vecs[i]);

    // Timeout: ready never comes, request held for exactly 4 WAIT cycles.
    mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h100;
    cycle();
    mem_read_in = 1'b0;
    for (int k = 0; k < 4; k++) check("timeout_req_held", {31'd0, bus_req}, 32'd1);
    repeat (3) cycle();
    check("timeout_req_4th", {31'd0, bus_req}, 32'd1);
    cycle();
    check("timeout_req_drop", {31'd0, bus_req}, 32'd0);
    check("timeout_error", {31'd0, bus_error_out}, 32'd1);
    check("timeout_rd_zero", read_data_out, 32'd0);
    check("timeout_stall", {31'd0, stall_out}, 32'd0);
    cycle();
    check("timeout_error_sticky", {31'd0, bus_error_out}, 32'd1);
    $display("timeout: req=%0b err=%0b rd=%h", bus_req, bus_error_out, read_data_out);
    exp_err = 1'b1;
    do_vec(14, '{1'b0, 3'b010, 32'h108, 32'h0, 32'h55AA55AA, 0, 1'b0, 4'b1111, 32'h108, 32'h0, 32'h55AA55AA});

    // Reset in the middle of WAIT.
    mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h104;
    cycle();
    mem_read_in = 1'b0;
    check("midwait_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    cycle();
    check_reset_values("midwait_reset");
    $display("mid-WAIT reset: req=%0b err=%0b rd=%h", bus_req, bus_error_out, read_data_out);
    reset = 1'b0;
    exp_err = 1'b0;
    cycle();
    do_vec(15, '{1'b0, 3'b010, 32'h10C, 32'h0, 32'h01234567, 0, 1'b0, 4'b1111, 32'h10C, 32'h0, 32'h01234567});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
